// File: rtl/ca_generation_engine.sv
// Serial 1-D cellular-automaton engine: one cell per cycle via an external rule lookup.
// Define CA_FIXED_BOUNDARY_EN for zero-padded edges; the default build wraps the row as a ring.
module ca_generation_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_i,
    output logic [2:0]       nbhd_o,
    input  logic             rule_bit_i,
    output logic [WIDTH-1:0] row_o,
    output logic             busy_o,
    output logic             gen_valid_o,
    output logic [CNT_W-1:0] gen_count_o
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] Seed = {{(WIDTH - 1){1'b0}}, 1'b1} << (WIDTH / 2);

    typedef enum logic [1:0] {StIdle, StCompute, StCommit} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  next_row_q, next_row_d;
    logic [WIDTH-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  gen_count_q, gen_count_d;
    logic              gen_valid_q, gen_valid_d;

    logic [IdxW-1:0]   idx_left, idx_right;
    logic              cell_left, cell_center, cell_right;

    always_comb begin
        idx_left    = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        idx_right   = (idx_q == '0) ? IdxLast : idx_q - 1'b1;
        cell_center = row_q[idx_q];
`ifdef CA_FIXED_BOUNDARY_EN
        cell_left   = (idx_q == IdxLast) ? 1'b0 : row_q[idx_left];
        cell_right  = (idx_q == '0) ? 1'b0 : row_q[idx_right];
`else
        cell_left   = row_q[idx_left];
        cell_right  = row_q[idx_right];
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        next_row_d  = next_row_q;
        row_d       = row_q;
        gen_count_d = gen_count_q;
        gen_valid_d = 1'b0;
        nbhd_o      = 3'b000;
        busy_o      = 1'b0;
        case (state_q)
            StIdle: begin
                if (step_i) begin
                    state_d = StCompute;
                    idx_d   = '0;
                end
            end
            StCompute: begin
                busy_o             = 1'b1;
                nbhd_o             = {cell_left, cell_center, cell_right};
                // row_q stays frozen here so every neighbourhood sees the old generation
                next_row_d[idx_q]  = rule_bit_i;
                if (idx_q == IdxLast) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StCommit: begin
                busy_o      = 1'b1;
                row_d       = next_row_q;
                gen_count_d = gen_count_q + 1'b1;
                gen_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            next_row_q  <= '0;
            row_q       <= Seed;
            gen_count_q <= '0;
            gen_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            next_row_q  <= next_row_d;
            row_q       <= row_d;
            gen_count_q <= gen_count_d;
            gen_valid_q <= gen_valid_d;
        end
    end

    assign row_o       = row_q;
    assign gen_count_o = gen_count_q;
    assign gen_valid_o = gen_valid_q;

endmodule

// File: tb/tb_ca_generation_engine.sv
// Bench for ca_generation_engine: directed and random generations against an arithmetic CA model.
// Uses a 3-bit generation counter so counter wrap is exercised within a few generations.
module tb_ca_generation_engine;

    localparam int W  = 16;
    localparam int CW = 3;
    localparam logic [W-1:0] SeedRow = 16'h0100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          step = 1'b0;
    logic [2:0]    nbhd;
    logic          rule_bit;
    logic [W-1:0]  row;
    logic          busy;
    logic          gen_valid;
    logic [CW-1:0] gen_count;

    logic [7:0]    rule_r = 8'd30;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pulses = 0;
    int            pulse_cyc[$];
    logic [W-1:0]  m_row;
    int            m_cnt;
    logic [W-1:0]  prev_row = '0;
    logic          prev_busy = 1'b0;

    ca_generation_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_i      (step),
        .nbhd_o      (nbhd),
        .rule_bit_i  (rule_bit),
        .row_o       (row),
        .busy_o      (busy),
        .gen_valid_o (gen_valid),
        .gen_count_o (gen_count)
    );

    always #5 clk = ~clk;

    // Rule-lookup stage: pure combinational table indexed by the neighbourhood.
    assign rule_bit = rule_r[nbhd];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (gen_valid === 1'b1) begin
            pulses <= pulses + 1;
            pulse_cyc.push_back(cyc);
        end
        if (reset_n && busy === 1'b0) chk("nbhd_idle", 64'(nbhd), 64'(0));
        if (prev_busy && busy === 1'b1) chk("row_stable", 64'(row), 64'(prev_row));
        prev_busy <= busy;
        prev_row  <= row;
    end

    function automatic logic [W-1:0] next_gen(input logic [W-1:0] r, input logic [7:0] rule);
        logic [W-1:0] n;
        int l, c, rt;
        n = '0;
        for (int i = 0; i < W; i++) begin
            c = int'(r[i]);
`ifdef CA_FIXED_BOUNDARY_EN
            l  = (i == W - 1) ? 0 : int'(r[(i + 1) % W]);
            rt = (i == 0) ? 0 : int'(r[(i + W - 1) % W]);
`else
            l  = int'(r[(i + 1) % W]);
            rt = int'(r[(i + W - 1) % W]);
`endif
            n[i] = rule[l * 4 + c * 2 + rt];
        end
        return n;
    endfunction

    task automatic do_reset(input logic [7:0] rl);
        @(posedge clk);
        #1 reset_n = 1'b0;
        step   = 1'b0;
        rule_r = rl;
        @(posedge clk);
        #1 reset_n = 1'b1;
        m_row = SeedRow;
        m_cnt = 0;
        chk("rst_row", 64'(row), 64'(SeedRow));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(gen_valid), 64'(0));
        chk("rst_count", 64'(gen_count), 64'(0));
    endtask

    // Called #1 after a rising edge with the DUT idle; edge 1 samples step, edge W+2 commits.
    task automatic run_gen();
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        chk("busy_start", 64'(busy), 64'(1));
        repeat (W) @(posedge clk);
        #1;
        chk("valid_not_early", 64'(gen_valid), 64'(0));
        chk("busy_commit", 64'(busy), 64'(1));
        m_row = next_gen(m_row, rule_r);
        m_cnt++;
        @(posedge clk);
        #1;
        chk("valid_latency", 64'(gen_valid), 64'(1));
        chk("gen_row", 64'(row), 64'(m_row));
        chk("gen_count", 64'(gen_count), 64'(m_cnt % (1 << CW)));
        chk("busy_done", 64'(busy), 64'(0));
    endtask

    initial begin
        int p0;
        int q0;
        int n;

        // Rule 30 from the seed
        do_reset(8'd30);
        run_gen();
        chk("r30_gen1", 64'(row), 64'h0380);
        chk("r30_cnt1", 64'(gen_count), 64'd1);
        run_gen();
        chk("r30_gen2", 64'(row), 64'h0640);

        // Rule 60, nine generations; counter wraps past 7
        do_reset(8'd60);
        for (int g = 1; g <= 9; g++) begin
            run_gen();
            if (g == 8) chk("r60_gen8", 64'(row), 64'h0101);
        end
`ifdef CA_FIXED_BOUNDARY_EN
        chk("r60_gen9", 64'(row), 64'h0181);
`else
        chk("r60_gen9", 64'(row), 64'h8181);
`endif
        chk("r60_cnt_wrap", 64'(gen_count), 64'd1);

        // Step pulsed mid-generation is dropped
        do_reset(8'd90);
        p0 = pulses;
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (5) @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (W + 20) @(posedge clk);
        #1;
        m_row = next_gen(m_row, rule_r);
        chk("ignore_pulses", 64'(pulses - p0), 64'd1);
        chk("ignore_count", 64'(gen_count), 64'd1);
        chk("ignore_row", 64'(row), 64'(m_row));

        // Reset at idx 7 aborts the generation; new rule loaded during that reset
        do_reset(8'd30);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        rule_r = 8'd110;
        @(posedge clk);
        #1 reset_n = 1'b1;
        p0 = pulses;
        m_row = SeedRow;
        m_cnt = 0;
        chk("abort_row", 64'(row), 64'(SeedRow));
        chk("abort_count", 64'(gen_count), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (W + 4) @(posedge clk);
        #1;
        chk("abort_no_pulse", 64'(pulses - p0), 64'd0);
        run_gen();

        // Step held high: back-to-back generations with rule 54
        do_reset(8'd54);
        p0 = pulses;
        q0 = pulse_cyc.size();
        step = 1'b1;
        repeat (3 * (W + 2)) @(posedge clk);
        #1 step = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) m_row = next_gen(m_row, rule_r);
        chk("held_pulses", 64'(pulses - p0), 64'd3);
        if (pulse_cyc.size() >= q0 + 3) begin
            chk("held_space1", 64'(pulse_cyc[q0 + 1] - pulse_cyc[q0]), 64'(W + 2));
            chk("held_space2", 64'(pulse_cyc[q0 + 2] - pulse_cyc[q0 + 1]), 64'(W + 2));
        end else begin
            chk("held_pulse_log", 64'(pulse_cyc.size() - q0), 64'd3);
        end
        chk("held_count", 64'(gen_count), 64'd3);
        chk("held_row", 64'(row), 64'(m_row));

        // Random rules and generation counts with idle gaps
        for (int t = 0; t < 6; t++) begin
            do_reset(8'($urandom));
            n = int'($urandom_range(1, 5));
            for (int g = 0; g < n; g++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                run_gen();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ca_generation_engine.md
CA_GENERATION_ENGINE -- requirements
Module: ca_generation_engine

Interface
REQ-001 Parameter WIDTH, 16, number of cells in the 1-D ring; legal range 4..64.
REQ-002 Parameter CNT_W, 16, width of the generation counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 step  input  1  request to compute one new generation; sampled only in IDLE.
REQ-006 nbhd  output  3  neighbourhood {left, center, right} presented to the rule-lookup stage.
REQ-007 rule_bit  input  1  next-state bit returned combinationally, same cycle, by the rule-lookup stage for nbhd.
REQ-008 row  output  WIDTH  current generation; bit 0 is the rightmost cell.
REQ-009 busy  output  1  high while a generation is in progress.
REQ-010 gen_valid  output  1  one-cycle pulse; row has just been updated.
REQ-011 gen_count  output  CNT_W  number of generations committed since reset.

Function
REQ-012 The FSM SHALL have states IDLE, COMPUTE, COMMIT.
REQ-013 In IDLE with step=1, the FSM SHALL go to COMPUTE and set the cell index idx to 0.
REQ-014 In COMPUTE, nbhd SHALL be {row[(idx+1) mod WIDTH], row[idx], row[(idx-1) mod WIDTH]}.
REQ-015 In COMPUTE, each cycle next_row[idx] SHALL be loaded with rule_bit.
REQ-016 In COMPUTE, idx SHALL increment; at idx=WIDTH-1 the FSM SHALL go to COMMIT.
REQ-017 In COMMIT, row SHALL load next_row and gen_count SHALL increment; the FSM SHALL then return to IDLE.
REQ-018 gen_valid SHALL be high exactly during the cycle after COMMIT, in which the new row is visible.
REQ-019 Latency: row and gen_valid SHALL update WIDTH+2 rising edges after the edge that samples step.
REQ-020 busy SHALL be high in COMPUTE and COMMIT and low in IDLE.
REQ-021 step while busy SHALL be ignored, not queued.
REQ-022 step held high SHALL start back-to-back generations, one per WIDTH+2 cycles.
REQ-023 row SHALL never change during COMPUTE; all neighbourhoods SHALL be taken from the old generation.
REQ-024 In IDLE, nbhd SHALL be 3'b000.
REQ-025 gen_count SHALL wrap from all-ones to 0 without any flag.

Reset
REQ-026 With reset_n=0 at a rising edge: state=IDLE, idx=0, next_row=0, busy=0, gen_valid=0, gen_count=0.
REQ-027 On reset, row SHALL load the seed: only bit WIDTH/2 set (0x0100 for WIDTH=16).
REQ-028 Reset mid-COMPUTE or mid-COMMIT SHALL abort the generation; no partial row update and no gen_valid pulse.
REQ-029 The rule-lookup stage reloads its rule during the same reset, so the first step after reset uses the new rule.

Configuration
REQ-030 Macro CA_FIXED_BOUNDARY_EN: when defined, cells outside 0..WIDTH-1 SHALL read as 0; nbhd at idx=WIDTH-1 SHALL use left=0 and at idx=0 SHALL use right=0.
REQ-031 When CA_FIXED_BOUNDARY_EN is undefined, the boundary SHALL wrap as a ring per REQ-014.

Verification
REQ-032 Rule 30, WIDTH=16, reset then one step -> after 18 edges gen_valid=1, row=0x0380, gen_count=1; second step -> row=0x0640.
REQ-033 Rule 60, nine steps, wrap build -> gen 8 row=0x0101; gen 9 row=0x8181.
REQ-034 Same as REQ-033 with CA_FIXED_BOUNDARY_EN defined -> gen 9 row=0x0181.
REQ-035 Pulse step again 5 cycles into COMPUTE -> exactly one gen_valid pulse; gen_count increments by 1 only.
REQ-036 Assert reset_n=0 at idx=7 of a generation -> row=0x0100, gen_count=0, no gen_valid pulse; a following step produces a correct generation 1.
REQ-037 step held high for 3*(WIDTH+2) cycles with rule 54 -> exactly 3 gen_valid pulses, spaced 18 cycles apart, gen_count=3.
